instr_fetch_stage: RTL and testbench
====================================

// Module: instr_fetch_stage
// PURPOSE
//   IF stage of the 5-stage pipeline: owns the PC and issues word requests to instruction memory.
//   Captures responses into the IF/ID register, which feeds opcode/funct to the ID-stage decoder.
//   Honours ID-stage stall and EX-stage branch redirect. Max one outstanding imem request.
// PARAMETERS
//   ADDR_W    32     PC / imem address width
//   DATA_W    32     instruction width (opcode = [31:26], funct = [5:0])
//   RESET_PC  32'h0  PC loaded on reset (bits [1:0] forced to 0)
// PORTS
//   clk             in   1       single clock; all state updates on rising edge
//   rst_n           in   1       asynchronous, active-low reset
//   imem_req_valid  out  1       request valid
//   imem_req_ready  in   1       memory accepts request this cycle
//   imem_req_addr   out  ADDR_W  word-aligned fetch address (= pc)
//   imem_rsp_valid  in   1       response data valid; in order, >=1 cycle after acceptance
//   imem_rsp_data   in   DATA_W  instruction word
//   stall           in   1       ID hazard: hold IF/ID contents
//   redirect_valid  in   1       branch taken: flush and refetch
//   redirect_pc     in   ADDR_W  branch target ([1:0] ignored, treated as 00)
//   if_valid        out  1       IF/ID holds a live instruction
//   if_instr        out  DATA_W  IF/ID instruction (32'h0 when flushed or reset)
//   if_pc           out  ADDR_W  address of if_instr
//   if_pc_plus4     out  ADDR_W  if_pc + 4 (mod 2^ADDR_W)
//   if_opcode       out  6       if_instr[31:26], combinational
//   if_funct        out  6       if_instr[5:0], combinational
// BEHAVIOUR
//   Reset: pc=RESET_PC, state=REQ, if_valid=0, if_instr=0, if_pc=0, if_pc_plus4=0, buffer empty.
//     imem_req_valid=0 while rst_n=0. Reset mid-request: the outstanding response is abandoned.
//   FSM states:
//     REQ:   req_valid=1, addr=pc. On valid&&ready: req_pc<=pc, pc<=pc+4 (wraps), go to WAIT.
//     WAIT:  req_valid=0. On rsp_valid:
//            - if load_ok=(!stall||!if_valid): IF/ID<={1,data,req_pc,req_pc+4}, go to REQ;
//            - else buf<={data,req_pc}, go to HOLD.
//     HOLD:  req_valid=0. When load_ok: IF/ID<=buf, go to REQ.
//     DRAIN: req_valid=0. On rsp_valid: discard data, go to REQ.
//   Redirect (highest priority, overrides stall):
//     - next cycle: if_valid=0, if_instr=0; pc<=redirect_pc&~3.
//     - REQ without handshake -> REQ. REQ with handshake same cycle -> DRAIN.
//     - WAIT without rsp -> DRAIN. WAIT with rsp same cycle -> REQ (rsp discarded).
//     - HOLD -> REQ (buf dropped).
//     - DRAIN without rsp -> DRAIN (pc updated again). DRAIN with rsp -> REQ.
//   Stall without redirect: if_* hold every cycle; no new request while in HOLD.
//   Latency: 1-cycle memory gives REQ(accept) -> rsp -> IF/ID valid on next edge; peak 1 instr / 2 cycles.
//   rsp_valid in REQ/HOLD (unsolicited) is ignored. imem_req_addr is stable while valid && !ready,
//     unless a redirect arrives.
// STRUCTURE
//   cpu_pkg: OP_RTYPE=6'h00, OP_LW=6'h23, OP_SW=6'h2B, OP_BEQ=6'h04, NOP_INSTR=32'h0,
//     fetch state encodings FS_REQ/FS_WAIT/FS_HOLD/FS_DRAIN (2 bits).
//   One sub-module is natural: if_id_reg (IF/ID register with load/flush, async active-low reset).
//   FSM, PC, and buffer stay in the top level.
// TESTING
//   1 Reset: assert rst_n=0 in WAIT -> req_valid=0, if_valid=0 immediately.
//     After release: first req addr=0x0000_0000.
//   2 Straight line, 1-cycle mem: 0x0->8C220004, 0x4->00430820 -> if_pc 0 then 4;
//     opcode 0x23 then 0x00/funct 0x20; valid every 2nd cycle.
//   3 Stall: stall=1 with if_valid=1, rsp 0xAC220008 arrives -> if_* unchanged, HOLD, req_valid=0;
//     stall=0 -> if_instr=AC220008 next edge.
//   4 Redirect in WAIT to 0x40 -> if_valid=0 next cycle, late rsp discarded (DRAIN), next req addr=0x40.
//   5 Simultaneous: redirect(0x80)+rsp in DRAIN -> REQ next cycle with addr 0x80;
//     redirect+stall -> flush still occurs.
//   6 Wrap/alignment: RESET_PC=0xFFFF_FFFC -> second req addr 0x0, if_pc_plus4=0x0;
//     redirect_pc=0x43 -> req addr 0x40.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode constants, the NOP encoding and the fetch FSM state encoding.
package cpu_pkg;

    localparam logic [5:0]  OP_RTYPE  = 6'h00;
    localparam logic [5:0]  OP_LW     = 6'h23;
    localparam logic [5:0]  OP_SW     = 6'h2B;
    localparam logic [5:0]  OP_BEQ    = 6'h04;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        FS_REQ   = 2'd0,
        FS_WAIT  = 2'd1,
        FS_HOLD  = 2'd2,
        FS_DRAIN = 2'd3
    } fetch_state_t;

    function automatic logic [5:0] instr_opcode(input logic [31:0] instr);
        return instr[31:26];
    endfunction

    function automatic logic [5:0] instr_funct(input logic [31:0] instr);
        return instr[5:0];
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: loads a fetched instruction with its PC, flush clears valid and instruction.
module if_id_reg
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              load,
    input  logic [DATA_W-1:0] load_instr,
    input  logic [ADDR_W-1:0] load_pc,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_instr,
    output logic [ADDR_W-1:0] if_pc,
    output logic [ADDR_W-1:0] if_pc_plus4
);

    logic              valid_reg;
    logic [DATA_W-1:0] instr_reg;
    logic [ADDR_W-1:0] pc_reg;
    logic [ADDR_W-1:0] pc_plus4_reg;

    // Flush wins over load so a redirect always kills whatever was arriving.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg    <= 1'b0;
            instr_reg    <= DATA_W'(NOP_INSTR);
            pc_reg       <= '0;
            pc_plus4_reg <= '0;
        end else if (flush) begin
            valid_reg <= 1'b0;
            instr_reg <= DATA_W'(NOP_INSTR);
        end else if (load) begin
            valid_reg    <= 1'b1;
            instr_reg    <= load_instr;
            pc_reg       <= load_pc;
            pc_plus4_reg <= load_pc + ADDR_W'(4);
        end
    end

    assign if_valid    = valid_reg;
    assign if_instr    = instr_reg;
    assign if_pc       = pc_reg;
    assign if_pc_plus4 = pc_plus4_reg;

endmodule

// File: rtl/instr_fetch_stage.sv
// IF stage: owns the PC, issues one outstanding word fetch at a time and fills the IF/ID register,
// honouring ID stall (with a one-entry response buffer) and EX branch redirects.
module instr_fetch_stage
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [DATA_W-1:0] imem_rsp_data,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_instr,
    output logic [ADDR_W-1:0] if_pc,
    output logic [ADDR_W-1:0] if_pc_plus4,
    output logic [5:0]        if_opcode,
    output logic [5:0]        if_funct
);

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);
    localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(4);

    fetch_state_t      state_reg;
    fetch_state_t      state_next;
    logic [ADDR_W-1:0] pc_reg;
    logic [ADDR_W-1:0] req_pc_reg;
    logic [ADDR_W-1:0] buf_pc_reg;
    logic [DATA_W-1:0] buf_instr_reg;

    logic              in_req;
    logic              handshake;
    logic              load_ok;
    logic              load_en;
    logic              load_from_buf;
    logic              buf_we;
    logic [DATA_W-1:0] load_instr;
    logic [ADDR_W-1:0] load_pc;

    // Gating with rst_n keeps the request low for the whole reset, not just after the first edge.
    assign imem_req_valid = in_req && rst_n;
    assign imem_req_addr  = pc_reg;
    assign handshake      = imem_req_valid && imem_req_ready;
    assign load_ok        = !stall || !if_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= FS_REQ;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            FS_REQ: begin
                if (handshake) begin
                    state_next = redirect_valid ? FS_DRAIN : FS_WAIT;
                end
            end
            FS_WAIT: begin
                if (redirect_valid) begin
                    state_next = imem_rsp_valid ? FS_REQ : FS_DRAIN;
                end else if (imem_rsp_valid) begin
                    state_next = load_ok ? FS_REQ : FS_HOLD;
                end
            end
            FS_HOLD: begin
                if (redirect_valid || load_ok) begin
                    state_next = FS_REQ;
                end
            end
            FS_DRAIN: begin
                if (imem_rsp_valid) begin
                    state_next = FS_REQ;
                end
            end
            default: state_next = FS_REQ;
        endcase
    end

    always_comb begin
        in_req        = (state_reg == FS_REQ);
        load_en       = 1'b0;
        load_from_buf = 1'b0;
        buf_we        = 1'b0;
        if (!redirect_valid) begin
            unique case (state_reg)
                FS_WAIT: begin
                    if (imem_rsp_valid) begin
                        load_en = load_ok;
                        buf_we  = !load_ok;
                    end
                end
                FS_HOLD: begin
                    load_en       = load_ok;
                    load_from_buf = load_ok;
                end
                default: ;
            endcase
        end
    end

    // A redirect overrides any same-cycle PC increment from an accepted request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg     <= RESET_PC & ALIGN_MASK;
            req_pc_reg <= '0;
        end else begin
            if (redirect_valid) begin
                pc_reg <= redirect_pc & ALIGN_MASK;
            end else if (handshake) begin
                pc_reg <= pc_reg + PC_STEP;
            end
            if (handshake) begin
                req_pc_reg <= pc_reg;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_instr_reg <= '0;
            buf_pc_reg    <= '0;
        end else if (buf_we) begin
            buf_instr_reg <= imem_rsp_data;
            buf_pc_reg    <= req_pc_reg;
        end
    end

    assign load_instr = load_from_buf ? buf_instr_reg : imem_rsp_data;
    assign load_pc    = load_from_buf ? buf_pc_reg    : req_pc_reg;

    if_id_reg #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_if_id_reg (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (redirect_valid),
        .load        (load_en),
        .load_instr  (load_instr),
        .load_pc     (load_pc),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .if_pc_plus4 (if_pc_plus4)
    );

    assign if_opcode = instr_opcode(if_instr[31:0]);
    assign if_funct  = instr_funct(if_instr[31:0]);

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Bench for instr_fetch_stage: directed scenarios plus a randomized run against a transaction-level model.
module tb_instr_fetch_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
    logic [31:0] imem_req_addr, imem_rsp_data;
    logic        stall, redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_instr, if_pc, if_pc_plus4;
    logic [5:0]  if_opcode, if_funct;

    logic        w_req_valid, w_req_ready, w_rsp_valid;
    logic [31:0] w_req_addr, w_rsp_data;
    logic        w_stall, w_redirect_valid;
    logic [31:0] w_redirect_pc;
    logic        w_if_valid;
    logic [31:0] w_if_instr, w_if_pc, w_if_pc_plus4;
    logic [5:0]  w_if_opcode, w_if_funct;

    int n_cmp = 0;
    int n_bad = 0;

    instr_fetch_stage dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_pc_plus4(if_pc_plus4),
        .if_opcode(if_opcode), .if_funct(if_funct)
    );

    instr_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(w_req_valid), .imem_req_ready(w_req_ready), .imem_req_addr(w_req_addr),
        .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(w_rsp_data),
        .stall(w_stall), .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc),
        .if_valid(w_if_valid), .if_instr(w_if_instr), .if_pc(w_if_pc), .if_pc_plus4(w_if_pc_plus4),
        .if_opcode(w_if_opcode), .if_funct(w_if_funct)
    );

    // Memory contents used by the randomized run: a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]} ^ 32'h5A5A_1234;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle_inputs();
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        w_req_ready = 1'b0; w_rsp_valid = 1'b0; w_rsp_data = '0;
        w_stall = 1'b0; w_redirect_valid = 1'b0; w_redirect_pc = '0;
        repeat (3) @(negedge clk);
        n_cmp++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL rst_hold_req_valid: got %b want 0", imem_req_valid); end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin n_bad++; $display("FAIL rst_first_req: got v=%b a=%h want v=1 a=00000000", imem_req_valid, imem_req_addr); end
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (imem_req_valid !== 1'b0 || if_valid !== 1'b0) begin n_bad++; $display("FAIL rst_async: got req_v=%b if_v=%b want 0 0", imem_req_valid, if_valid); end
        n_cmp++; if (if_instr !== 32'h0 || if_pc !== 32'h0 || if_pc_plus4 !== 32'h0) begin n_bad++; $display("FAIL rst_ifid: got %h %h %h want zeros", if_instr, if_pc, if_pc_plus4); end
        @(negedge clk);
        rst_n = 1'b1;
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        n_cmp++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL rst_abandoned_rsp: got if_valid=%b want 0", if_valid); end
        n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin n_bad++; $display("FAIL rst_rerequest: got v=%b a=%h want 1 00000000", imem_req_valid, imem_req_addr); end
        $display("test_reset done");
    endtask

    task automatic test_straight_line();
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        n_cmp++; if (imem_req_valid !== 1'b0 || if_valid !== 1'b0) begin n_bad++; $display("FAIL sl_wait: got req_v=%b if_v=%b want 0 0", imem_req_valid, if_valid); end
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h8C22_0004;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== 32'h8C22_0004) begin n_bad++; $display("FAIL sl_instr0: got v=%b pc=%h i=%h want 1 00000000 8c220004", if_valid, if_pc, if_instr); end
        n_cmp++; if (if_opcode !== 6'h23 || if_pc_plus4 !== 32'h4) begin n_bad++; $display("FAIL sl_op0: got op=%h pc4=%h want 23 00000004", if_opcode, if_pc_plus4); end
        n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h4) begin n_bad++; $display("FAIL sl_req1: got v=%b a=%h want 1 00000004", imem_req_valid, imem_req_addr); end
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0043_0820;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        n_cmp++; if (if_pc !== 32'h4 || if_instr !== 32'h0043_0820) begin n_bad++; $display("FAIL sl_instr1: got pc=%h i=%h want 00000004 00430820", if_pc, if_instr); end
        n_cmp++; if (if_opcode !== 6'h00 || if_funct !== 6'h20) begin n_bad++; $display("FAIL sl_op1: got op=%h fn=%h want 00 20", if_opcode, if_funct); end
        $display("test_straight_line done");
    endtask

    task automatic test_stall();
        imem_req_ready = 1'b1; stall = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'hAC22_0008;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        n_cmp++; if (if_instr !== 32'h0043_0820 || if_pc !== 32'h4 || if_valid !== 1'b1) begin n_bad++; $display("FAIL st_hold: got v=%b pc=%h i=%h want 1 00000004 00430820", if_valid, if_pc, if_instr); end
        n_cmp++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL st_noreq: got req_v=%b want 0", imem_req_valid); end
        @(negedge clk);
        n_cmp++; if (imem_req_valid !== 1'b0 || if_instr !== 32'h0043_0820) begin n_bad++; $display("FAIL st_hold2: got req_v=%b i=%h want 0 00430820", imem_req_valid, if_instr); end
        stall = 1'b0;
        @(negedge clk);
        n_cmp++; if (if_instr !== 32'hAC22_0008 || if_pc !== 32'h8 || if_opcode !== 6'h2B) begin n_bad++; $display("FAIL st_release: got pc=%h i=%h op=%h want 00000008 ac220008 2b", if_pc, if_instr, if_opcode); end
        n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hC) begin n_bad++; $display("FAIL st_nextreq: got v=%b a=%h want 1 0000000c", imem_req_valid, imem_req_addr); end
        $display("test_stall done");
    endtask

    task automatic test_redirect_wait();
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        @(negedge clk);
        redirect_valid = 1'b0;
        n_cmp++; if (if_valid !== 1'b0 || if_instr !== 32'h0) begin n_bad++; $display("FAIL rw_flush: got v=%b i=%h want 0 00000000", if_valid, if_instr); end
        n_cmp++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL rw_drain_noreq: got req_v=%b want 0", imem_req_valid); end
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h1234_5678;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        n_cmp++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL rw_discard: got if_valid=%b want 0", if_valid); end
        n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h40) begin n_bad++; $display("FAIL rw_target: got v=%b a=%h want 1 00000040", imem_req_valid, imem_req_addr); end
        $display("test_redirect_wait done");
    endtask

    task automatic test_simultaneous();
        imem_req_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h60;
        @(negedge clk);
        imem_req_ready = 1'b0;
        n_cmp++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL sim_drain: got req_v=%b want 0", imem_req_valid); end
        redirect_pc = 32'h80; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h7777_7777;
        @(negedge clk);
        redirect_valid = 1'b0; imem_rsp_valid = 1'b0;
        n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h80 || if_valid !== 1'b0) begin n_bad++; $display("FAIL sim_req80: got v=%b a=%h if_v=%b want 1 00000080 0", imem_req_valid, imem_req_addr, if_valid); end
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h1111_1111;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'h80) begin n_bad++; $display("FAIL sim_load80: got v=%b pc=%h want 1 00000080", if_valid, if_pc); end
        stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h100;
        @(negedge clk);
        stall = 1'b0; redirect_valid = 1'b0;
        n_cmp++; if (if_valid !== 1'b0 || if_instr !== 32'h0) begin n_bad++; $display("FAIL sim_stall_flush: got v=%b i=%h want 0 00000000", if_valid, if_instr); end
        n_cmp++; if (imem_req_addr !== 32'h100) begin n_bad++; $display("FAIL sim_stall_pc: got a=%h want 00000100", imem_req_addr); end
        $display("test_simultaneous done");
    endtask

    task automatic test_wrap_align();
        n_cmp++; if (w_req_valid !== 1'b1 || w_req_addr !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wr_first: got v=%b a=%h want 1 fffffffc", w_req_valid, w_req_addr); end
        w_req_ready = 1'b1;
        @(negedge clk);
        w_req_ready = 1'b0;
        w_rsp_valid = 1'b1; w_rsp_data = 32'h8C22_0004;
        @(negedge clk);
        w_rsp_valid = 1'b0;
        n_cmp++; if (w_if_pc !== 32'hFFFF_FFFC || w_if_pc_plus4 !== 32'h0) begin n_bad++; $display("FAIL wr_pc4: got pc=%h pc4=%h want fffffffc 00000000", w_if_pc, w_if_pc_plus4); end
        n_cmp++; if (w_req_valid !== 1'b1 || w_req_addr !== 32'h0) begin n_bad++; $display("FAIL wr_second: got v=%b a=%h want 1 00000000", w_req_valid, w_req_addr); end
        w_redirect_valid = 1'b1; w_redirect_pc = 32'h43;
        @(negedge clk);
        w_redirect_valid = 1'b0;
        n_cmp++; if (w_req_valid !== 1'b1 || w_req_addr !== 32'h40) begin n_bad++; $display("FAIL wr_align: got v=%b a=%h want 1 00000040", w_req_valid, w_req_addr); end
        $display("test_wrap_align done");
    endtask

    task automatic test_random(input int ncyc);
        logic [31:0] exp_req_pc, exp_dlv_pc, rsp_addr, tgt, w;
        logic [31:0] p_instr, p_pc, p_pc4;
        logic        p_valid;
        bit          outstanding, busy, accept, p_redirect, p_hold;
        int          lat, deliveries;
        rst_n = 1'b0;
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        exp_req_pc = 32'h0; exp_dlv_pc = 32'h0; rsp_addr = 32'h0;
        outstanding = 1'b0; p_redirect = 1'b0; p_hold = 1'b0; p_valid = 1'b0;
        p_instr = '0; p_pc = '0; p_pc4 = '0; lat = 0; deliveries = 0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            if (p_redirect) begin
                n_cmp++; if (if_valid !== 1'b0 || if_instr !== 32'h0) begin n_bad++; $display("FAIL rnd_flush c=%0d: got v=%b i=%h want 0 00000000", c, if_valid, if_instr); end
            end else if (p_hold) begin
                n_cmp++; if ({if_valid, if_instr, if_pc, if_pc_plus4} !== {p_valid, p_instr, p_pc, p_pc4}) begin n_bad++; $display("FAIL rnd_stall_hold c=%0d: got pc=%h i=%h want pc=%h i=%h", c, if_pc, if_instr, p_pc, p_instr); end
            end
            if (if_valid === 1'b1 && (!p_valid || if_pc !== p_pc)) begin
                deliveries++;
                w = mem_word(exp_dlv_pc);
                n_cmp++; if (if_pc !== exp_dlv_pc) begin n_bad++; $display("FAIL rnd_order c=%0d: got pc=%h want %h", c, if_pc, exp_dlv_pc); end
                n_cmp++; if (if_instr !== w || if_pc_plus4 !== exp_dlv_pc + 32'd4) begin n_bad++; $display("FAIL rnd_data c=%0d: got i=%h pc4=%h want %h %h", c, if_instr, if_pc_plus4, w, exp_dlv_pc + 32'd4); end
                n_cmp++; if (if_opcode !== w[31:26] || if_funct !== w[5:0]) begin n_bad++; $display("FAIL rnd_decode c=%0d: got op=%h fn=%h want %h %h", c, if_opcode, if_funct, w[31:26], w[5:0]); end
                exp_dlv_pc = exp_dlv_pc + 32'd4;
            end
            p_valid = if_valid; p_instr = if_instr; p_pc = if_pc; p_pc4 = if_pc_plus4;

            stall          = ($urandom_range(0, 99) < 30);
            redirect_valid = ($urandom_range(0, 99) < 4);
            tgt            = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                         : 32'($urandom_range(0, 4095));
            redirect_pc    = tgt;
            imem_req_ready = ($urandom_range(0, 99) < 60);
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
            busy = outstanding;
            if (outstanding) begin
                if (lat == 0) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = mem_word(rsp_addr);
                    outstanding    = 1'b0;
                end else begin
                    lat--;
                end
            end else if ($urandom_range(0, 9) == 0) begin
                imem_rsp_valid = 1'b1;
            end
            accept = (imem_req_valid === 1'b1) && imem_req_ready;
            if (accept) begin
                n_cmp++; if (busy) begin n_bad++; $display("FAIL rnd_one_outstanding c=%0d: got accept while busy want none", c); end
                n_cmp++; if (imem_req_addr !== exp_req_pc) begin n_bad++; $display("FAIL rnd_req_addr c=%0d: got %h want %h", c, imem_req_addr, exp_req_pc); end
                outstanding = 1'b1;
                rsp_addr    = imem_req_addr;
                lat         = $urandom_range(0, 2);
            end
            if (redirect_valid) begin
                exp_req_pc = tgt & 32'hFFFF_FFFC;
                exp_dlv_pc = tgt & 32'hFFFF_FFFC;
            end else if (accept) begin
                exp_req_pc = exp_req_pc + 32'd4;
            end
            p_redirect = redirect_valid;
            p_hold     = stall && (if_valid === 1'b1) && !redirect_valid;
        end
        idle_inputs();
        n_cmp++; if (deliveries < ncyc / 40) begin n_bad++; $display("FAIL rnd_progress: got %0d deliveries want >= %0d", deliveries, ncyc / 40); end
        $display("test_random done: %0d deliveries", deliveries);
    endtask

    initial begin
        test_reset();
        test_straight_line();
        test_stall();
        test_redirect_wait();
        test_simultaneous();
        test_wrap_align();
        test_random(4000);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
